// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: op-codes,
// program-word field offsets and sequencer FSM encoding.
package alu_pkg;

   // ALU Select op-codes
   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_AND  = 3'd2,
      OP_OR   = 3'd3,
      OP_XOR  = 3'd4,
      OP_NOT  = 3'd5,
      OP_SHL  = 3'd6,
      OP_PASS = 3'd7
   } alu_op_e;

   // Program word layout: {chain, Select[2:0], A[3:0], B[3:0], C[3:0]}
   localparam int CHAIN_BIT = 15;
   localparam int SEL_LSB   = 12;
   localparam int A_LSB     = 8;
   localparam int B_LSB     = 4;
   localparam int C_LSB     = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAPTURE,
      S_DONE
   } state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command/response bus between the sequencer (master) and the registered ALU (slave).
interface alu_cmd_sequencer_if;
   logic [2:0] Select;
   logic [3:0] A;
   logic [3:0] B;
   logic [3:0] C;
   logic [3:0] alu_result;
   logic       alu_carry;

   modport master (output Select, A, B, C, input alu_result, alu_carry);
   modport slave  (input Select, A, B, C, output alu_result, alu_carry);
endinterface

// File: rtl/alu_cmd_mem.sv
// Program RAM (16-bit words) and result RAM ({carry, RegOut}), one write
// port each, asynchronous read. Contents are not reset.
module alu_cmd_mem #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_waddr,
   input  logic [15:0]   prog_wdata,
   input  logic [AW-1:0] prog_raddr,
   output logic [15:0]   prog_rdata,
   input  logic          res_we,
   input  logic [AW-1:0] res_waddr,
   input  logic [4:0]    res_wdata,
   input  logic [AW-1:0] res_raddr,
   output logic [4:0]    res_rdata
);

   logic [15:0] prog_mem [DEPTH];
   logic [4:0]  res_mem  [DEPTH];

   // Program write port
   always_ff @(posedge clock) begin
      if (prog_we) prog_mem[prog_waddr] <= prog_wdata;
   end

   // Result write port
   always_ff @(posedge clock) begin
      if (res_we) res_mem[res_waddr] <= res_wdata;
   end

   assign prog_rdata = prog_mem[prog_raddr];
   assign res_rdata  = res_mem[res_raddr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Runs a host-loaded program against a registered ALU: one entry at a time,
// ISSUE -> WAIT(ALU_LAT) -> CAPTURE, optional chaining of the previous
// result into A, and a one-cycle done pulse at the end of the run.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int  PROG_DEPTH = 8,
   parameter int  ALU_LAT    = 1,
   localparam int AW         = $clog2(PROG_DEPTH)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [15:0]         wr_data,
   input  logic [AW:0]         prog_len,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                carry_any,
   input  logic [AW-1:0]       rd_addr,
   output logic [4:0]          rd_data,
   alu_cmd_sequencer_if.master alu
);

   localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   state_e        state;
   logic [AW-1:0] idx;
   logic [AW:0]   len_q;
   logic [AW:0]   len_clamp;
   logic [CW-1:0] cnt;
   logic [3:0]    last_result;
   logic [2:0]    sel_q;
   logic [3:0]    a_q, b_q, c_q;
   logic [15:0]   entry;
   logic          last_entry;

   assign len_clamp  = (prog_len > (AW+1)'(PROG_DEPTH)) ? (AW+1)'(PROG_DEPTH) : prog_len;
   assign last_entry = ({1'b0, idx} == len_q - 1'b1);

   // Writes from the host land only while idle, including the start cycle,
   // so a run always sees a program written alongside its start pulse.
   alu_cmd_mem #(.DEPTH(PROG_DEPTH), .AW(AW)) u_mem (
      .clock      (clock),
      .prog_we    (wr_en && (state == S_IDLE)),
      .prog_waddr (wr_addr),
      .prog_wdata (wr_data),
      .prog_raddr (idx),
      .prog_rdata (entry),
      .res_we     (state == S_CAPTURE),
      .res_waddr  (idx),
      .res_wdata  ({alu.alu_carry, alu.alu_result}),
      .res_raddr  (rd_addr),
      .res_rdata  (rd_data)
   );

   assign alu.Select = sel_q;
   assign alu.A      = a_q;
   assign alu.B      = b_q;
   assign alu.C      = c_q;

   // Sequencer FSM with registered command and status outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         idx         <= '0;
         len_q       <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         carry_any   <= 1'b0;
         last_result <= 4'd0;
         sel_q       <= 3'd0;
         a_q         <= 4'd0;
         b_q         <= 4'd0;
         c_q         <= 4'd0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy        <= 1'b1;
                  carry_any   <= 1'b0;
                  last_result <= 4'd0;
                  idx         <= '0;
                  len_q       <= len_clamp;
                  if (len_clamp == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               sel_q <= entry[SEL_LSB +: 3];
               a_q   <= entry[CHAIN_BIT] ? last_result : entry[A_LSB +: 4];
               b_q   <= entry[B_LSB +: 4];
               c_q   <= entry[C_LSB +: 4];
               cnt   <= CW'(ALU_LAT - 1);
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt == '0) state <= S_CAPTURE;
               else           cnt   <= cnt - 1'b1;
            end
            S_CAPTURE: begin
               last_result <= alu.alu_result;
               carry_any   <= carry_any | alu.alu_carry;
               if (last_entry) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= S_ISSUE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a registered ALU model, a
// run-level reference model and a per-cycle compare process.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   localparam int PD  = 8;
   localparam int AW  = 3;
   localparam int LAT = 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [15:0]   wr_data = '0;
   logic [AW:0]   prog_len = '0;
   logic          start = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          busy, done, carry_any;
   logic [4:0]    rd_data;

   int n_cmp = 0;
   int n_bad = 0;

   alu_cmd_sequencer_if bus ();

   alu_cmd_sequencer #(.PROG_DEPTH(PD), .ALU_LAT(LAT)) dut (
      .clock     (clock),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .prog_len  (prog_len),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .carry_any (carry_any),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .alu       (bus)
   );

   always #5 clock = ~clock;

   // ALU behaviour: {carry, result}
   function automatic logic [4:0] alu_f(logic [2:0] s, logic [3:0] a, logic [3:0] b, logic [3:0] c);
      case (s)
         OP_ADD:  return {1'b0, a} + {1'b0, b};
         OP_SUB:  return {1'b0, a} - {1'b0, b};
         OP_AND:  return {1'b0, a & b};
         OP_OR:   return {1'b0, a | b};
         OP_XOR:  return {1'b0, a ^ b};
         OP_NOT:  return {1'b0, ~a};
         OP_SHL:  return {a, 1'b0};
         default: return {1'b0, c};
      endcase
   endfunction

   // Registered ALU, one cycle latency
   initial {bus.alu_carry, bus.alu_result} = 5'd0;
   always @(posedge clock)
      {bus.alu_carry, bus.alu_result} <= alu_f(bus.Select, bus.A, bus.B, bus.C);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit          chk_en = 0;
   int          cyc = 0;
   bit          active = 0;
   int          k_edge = 0, done_edge = 0, elen = 0;
   logic [15:0] pmem [PD];
   logic [4:0]  rmem [PD];
   bit          rvalid [PD];
   logic [14:0] eop [PD];
   logic [4:0]  eres [PD];
   logic [14:0] hold_op = '0;
   bit          exp_ca = 0;

   // Each run: compute every issued command and result up front from the
   // program, then release them at the issue / capture edges of the run.
   always @(posedge clock) begin
      bit          was_idle;
      int          i;
      logic [3:0]  last, a;
      was_idle = !active;
      cyc++;
      if (was_idle && wr_en) pmem[wr_addr] = wr_data;
      if (reset) begin
         active  = 0;
         hold_op = '0;
         exp_ca  = 0;
      end else if (active) begin
         if (cyc > k_edge && cyc <= done_edge) begin
            if ((cyc - k_edge - 1) % 3 == 0) hold_op = eop[(cyc - k_edge - 1) / 3];
            if ((cyc - k_edge) % 3 == 0) begin
               i = (cyc - k_edge) / 3 - 1;
               rmem[i]   = eres[i];
               rvalid[i] = 1;
               exp_ca    = exp_ca | eres[i][4];
            end
         end
         if (cyc == done_edge + 1) active = 0;
      end else if (start) begin
         elen = (int'(prog_len) > PD) ? PD : int'(prog_len);
         last = 4'd0;
         for (int j = 0; j < elen; j++) begin
            a       = pmem[j][15] ? last : pmem[j][11:8];
            eop[j]  = {pmem[j][14:12], a, pmem[j][7:4], pmem[j][3:0]};
            eres[j] = alu_f(pmem[j][14:12], a, pmem[j][7:4], pmem[j][3:0]);
            last    = eres[j][3:0];
         end
         exp_ca    = 0;
         active    = 1;
         k_edge    = cyc;
         done_edge = cyc + 3 * elen;
      end
   end

   // Per-cycle compare of all DUT outputs against the model
   always @(negedge clock) begin
      if (chk_en) begin
         chk("busy", busy, active);
         chk("done", done, active && (cyc == done_edge));
         chk("carry_any", carry_any, exp_ca);
         chk("alu_cmd", {bus.Select, bus.A, bus.B, bus.C}, hold_op);
         if (rvalid[rd_addr]) chk("rd_data", rd_data, rmem[rd_addr]);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] ad, input logic [15:0] d);
      wr_en = 1; wr_addr = ad; wr_data = d;
      tick();
      wr_en = 0;
   endtask

   task automatic launch(input logic [AW:0] len);
      prog_len = len; start = 1;
      tick();
      start = 0;
   endtask

   // n counts edges since the start cycle; bounded wait for done
   task automatic wait_done(input string nm, input int n0, input int exp_n);
      int n;
      n = n0;
      while (!done && n < 60) begin
         tick();
         n++;
      end
      chk(nm, n, exp_n);
   endtask

   task automatic read_chk(input string nm, input logic [AW-1:0] ad, input logic [4:0] exp);
      rd_addr = ad;
      #1;
      chk(nm, rd_data, exp);
   endtask

   initial begin
      int nd;
      for (int i = 0; i < PD; i++) rvalid[i] = 0;
      reset = 1;
      tick(); tick();
      chk_en = 1;
      reset = 0;
      tick();
      // reset state
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cmd", {bus.Select, bus.A, bus.B, bus.C}, 15'd0);
      chk("rst_carry", carry_any, 0);

      // single add 3+4
      wr(0, 16'h0340);
      launch(1);
      wait_done("t2_latency", 1, 4);
      read_chk("t2_res0", 0, 5'h07);
      tick(); tick();

      // 9+9, then chained AND with B=2
      wr(0, 16'h0990);
      wr(1, 16'hAF20);
      launch(2);
      tick(); tick(); tick(); tick();
      chk("t3_chain_A", bus.A, 4'd2);
      wait_done("t3_latency", 5, 7);
      chk("t3_carry_any", carry_any, 1);
      read_chk("t3_res0", 0, 5'h12);
      read_chk("t3_res1", 1, 5'h02);
      tick(); tick();

      // zero-length run
      launch(0);
      chk("t4_done", done, 1);
      chk("t4_busy", busy, 1);
      tick();
      chk("t4_done_off", done, 0);
      chk("t4_busy_off", busy, 0);
      chk("t4_sel_held", bus.Select, 3'd2);
      tick();

      // start during WAIT of 3-entry run is ignored
      wr(0, 16'h0570);
      wr(1, 16'h9070);
      wr(2, 16'h1570);
      launch(3);
      tick();
      start = 1;
      tick();
      start = 0;
      wait_done("t5_latency", 3, 10);
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) nd++;
      end
      chk("t5_extra_done", nd, 0);
      read_chk("t5_res1", 1, 5'h05);
      read_chk("t5_res2", 2, 5'h1E);
      chk("t5_carry_any", carry_any, 1);

      // prog_len above depth clamps to a full program
      for (int i = 0; i < PD; i++) wr(AW'(i), 16'h0010 | (16'(i) << 8));
      launch(4'hF);
      wait_done("clamp_latency", 1, 25);
      read_chk("clamp_res7", 7, 5'h08);
      chk("clamp_carry_any", carry_any, 0);
      tick(); tick();

      // reset mid-WAIT, then a fresh run with write + start together
      wr(0, 16'h0570);
      launch(3);
      tick();
      reset = 1;
      tick();
      reset = 0;
      chk("t6_busy", busy, 0);
      chk("t6_done", done, 0);
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) nd++;
      end
      chk("t6_no_done", nd, 0);
      wr_en = 1; wr_addr = 0; wr_data = 16'h1730;
      prog_len = 1; start = 1;
      tick();
      wr_en = 0; start = 0;
      wait_done("t6_latency", 1, 4);
      read_chk("t6_res0", 0, 5'h04);
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
